uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive-side UART deserializer that consumes the asynchronous `uart_rx` line driven by the UVM UART driver through `uart_if_clocking`. It synchronizes the line, detects start bits, samples 8N1 frames at mid-bit, and presents each byte on a single-entry valid/ready output toward the frame parser. It reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLK_FREQ_HZ`, 125_000_000, system clock frequency.
- `BAUD_RATE`, 115200, line rate.
- `BIT_CYCLES`, `CLK_FREQ_HZ/BAUD_RATE` (1085), clocks per bit; localparam `HALF_CYCLES = BIT_CYCLES/2` (542).
- `clk  in  1  system clock`
- `rst  in  1  reset; synchronous, active-high`
- `uart_rx  in  1  asynchronous serial input, idle high`
- `rx_data  out  8  received byte, LSB first on line`
- `rx_valid  out  1  rx_data holds an unconsumed byte`
- `rx_ready  in  1  consumer accepts byte when rx_valid && rx_ready`
- `rx_busy  out  1  high in any state other than IDLE`
- `frame_error  out  1  one-cycle pulse: stop bit sampled low`
- `overrun  out  1  one-cycle pulse: byte completed while holding register full`

## Operation
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `rx_busy`=0, `frame_error`=0, `overrun`=0. The synchronizer flops reset to 1. The FSM resets to IDLE and the bit counter and cycle counter reset to 0.
- 2-flop synchronizer on `uart_rx`, then a 1-flop history for falling-edge detection (`sync`=0, `prev`=1).
- **IDLE**: on a falling edge, clear the cycle counter and go to START.
- **START**: at count `HALF_CYCLES-1`, sample the line.
  - Sample = 1: treat as a glitch and return to IDLE. No pulse.
  - Sample = 0: clear the counter and go to DATA.
- **DATA**: at each count `BIT_CYCLES-1`, shift the sample into `shreg[7]` with a right shift and clear the counter. After the 8th sample, go to STOP.
- **STOP**: at count `BIT_CYCLES-1`, sample the line.
  - Sample = 1: deliver the byte and go to IDLE.
  - Sample = 0: pulse `frame_error`, discard the byte, and go to BREAK.
- **BREAK**: wait until `sync`=1, then go to IDLE. This prevents retriggering on a held-low line.
- **Delivery**:
  - If `rx_valid`=0, or `rx_valid && rx_ready` in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: keep the old byte, drop the new one, and pulse `overrun`.
- `rx_valid` clears on the `rx_valid && rx_ready` cycle when no delivery coincides.
- Reset mid-frame: all state returns to reset values on the next edge. A partial byte is never delivered.

## Timing
- Edge detection occurs 3 clocks after `uart_rx` falls: 2 synchronizer clocks plus 1 history clock.
- Start sample at detect + `HALF_CYCLES`. Data bit k is sampled at detect + `HALF_CYCLES` + (k+1)·`BIT_CYCLES`. The stop bit is sampled at detect + `HALF_CYCLES` + 9·`BIT_CYCLES`.
- `rx_valid` rises 1 clock after the stop sample, which is about a half bit before the end of the line's stop bit.
- The FSM is back in IDLE immediately after the stop sample. A start edge during the remaining stop-bit time or any later gap (including a 0-cycle gap) is accepted.
- `frame_error` and `overrun` are asserted for exactly 1 clock, in the same cycle `rx_valid` would have been updated.
- Counters are 11 bits wide, sufficient for `BIT_CYCLES` up to 2047; elaboration asserts `BIT_CYCLES >= 16`.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: every sample point (start, data, stop) uses the 2-of-3 majority of `sync` at counts N-2, N-1 and N. The decision cycle is unchanged.
- Macro undefined: single sample of `sync` at count N.

## Structure
- Package `uart_rx_pkg`:
  - State enum `uart_rx_state_e` {IDLE, START, DATA, STOP, BREAK}.
  - Default `CLK_FREQ_HZ`/`BAUD_RATE` constants.
  - `UART_DATA_BITS` = 8.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector. Outputs `sync` and `fall`; reset value 1/0.

## Test plan
- Drive 0xA5 at 1085 cycles/bit with `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=0xA5 at falling edge + 3 + 542 + 9·1085 + 1 clocks (±1); no error pulses.
- Drive 0x5A, 0xA1, 0x12, 0x34, 0xBC with 100-cycle gaps, then 20 bytes 0x00–0x13 with 50-cycle gaps → exactly 25 bytes received in order; `frame_error`=`overrun`=0.
- Hold `uart_rx` low for 200 cycles, then high → no `rx_valid`, `rx_busy` returns to 0 after about 545 clocks.
- Drive 0x3C with the stop bit low, then hold low for 3000 cycles, then idle → one `frame_error` pulse, no `rx_valid`, no retrigger until the line is high.
- With `rx_ready`=0, drive 0x11 then 0x22 → `rx_data` stays 0x11, one `overrun` pulse. Raising `rx_ready` for 1 clock clears `rx_valid`.
- With `UART_RX_MAJORITY_VOTE_EN` defined, drive 0xFF with a 1-clock low glitch at the mid-bit of bit 3 → `rx_data`=0xFF. Without the macro, the glitch aligned to the sample cycle → `rx_data`=0xF7.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive deserializer
//
// Purpose: state encoding, default line parameters, counter types and the
//          2-of-3 vote helper used by uart_rx_deserializer and uart_rx_sync.
// Ports:   none (package).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 125_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE   = 115_200;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CNT_W     = 11;
  localparam int unsigned UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

  typedef logic [UART_CNT_W-1:0]     uart_cnt_t;
  typedef logic [UART_BIT_IDX_W-1:0] uart_bit_idx_t;
  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer and falling-edge detector for uart_rx
//
// Purpose: brings the asynchronous serial line into the clk domain and flags
//          a 1 -> 0 transition of the synchronized line.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   uart_rx  in   asynchronous serial line, idle high
//   sync     out  synchronized line level (reset 1)
//   fall     out  high for one cycle when sync goes 1 -> 0 (reset 0)
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic sync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = uart_rx;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // All three flops reset to the idle line level so leaving reset never
  // looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receiver with single-entry valid/ready output
//
// Purpose: detects start bits on the synchronized line, samples each bit at
//          mid-bit, and hands completed bytes to a one-entry holding register.
//          Framing errors and overruns are reported as one-cycle pulses.
// Optional feature: define UART_RX_MAJORITY_VOTE_EN to take every sample as
//          the 2-of-3 majority of the line at counts N-2, N-1 and N.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   uart_rx      in   asynchronous serial line, idle high
//   rx_data      out  received byte (LSB first on the line)
//   rx_valid     out  rx_data holds an unconsumed byte
//   rx_ready     in   consumer takes the byte when rx_valid && rx_ready
//   rx_busy      out  receiver is not in IDLE
//   frame_error  out  one-cycle pulse: stop bit sampled low
//   overrun      out  one-cycle pulse: byte completed while holding register full
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned BAUD_RATE   = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned BIT_CYCLES  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;

  localparam uart_cnt_t     BIT_LAST  = uart_cnt_t'(BIT_CYCLES - 1);
  localparam uart_cnt_t     HALF_LAST = uart_cnt_t'(HALF_CYCLES - 1);
  localparam uart_bit_idx_t LAST_BIT  = uart_bit_idx_t'(UART_DATA_BITS - 1);

  if (BIT_CYCLES < 16 || BIT_CYCLES > 2047) begin : g_bit_cycles_check
    $error("uart_rx_deserializer: BIT_CYCLES must be within 16..2047");
  end

  logic sync;
  logic fall;
  logic sample;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .sync    (sync),
    .fall    (fall)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two cycles of line history; together with the current sync value this
  // gives the levels at counts N-2, N-1 and N at every decision point.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], sync};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign sample = maj3(hist_q[1], hist_q[0], sync);
`else
  assign sample = sync;
`endif

  uart_rx_state_e state_q, state_d;
  uart_cnt_t      cnt_q, cnt_d;
  uart_bit_idx_t  bit_cnt_q, bit_cnt_d;
  uart_byte_t     shreg_q, shreg_d;
  uart_byte_t     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_error_q, frame_error_d;
  logic           overrun_q, overrun_d;
  logic           deliver;

  // Receive FSM: counter runs freely inside START/DATA/STOP and is cleared
  // at every decision point, so each bit period is measured from the last.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + uart_cnt_t'(1);
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    deliver       = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = sample ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {sample, shreg_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + uart_bit_idx_t'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end

      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start.
        cnt_d = '0;
        if (sync) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Single-entry holding register. A delivery may refill the register in the
  // same cycle the consumer drains it; otherwise the new byte is dropped.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    overrun_d  = 1'b0;

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = (state_q != IDLE);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  // 7.3728 MHz / 115200 gives 64 clocks per bit, keeping the run short.
  localparam int unsigned CLK_HZ = 7_372_800;
  localparam int unsigned BAUD   = 115_200;
  localparam int BIT    = 64;
  localparam int HALF   = 32;
  localparam int DETECT = 3;
  localparam int STOP_SAMPLE = DETECT + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] recv_mem [0:255];
  int         recv_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;

  uart_rx_deserializer #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        recv_mem[recv_cnt] = rx_data;
        recv_cnt = recv_cnt + 1;
      end
      if (frame_error) fe_cnt = fe_cnt + 1;
      if (overrun) ov_cnt = ov_cnt + 1;
      if (rx_valid && !valid_prev) rise_cyc = cyc;
    end
    valid_prev = rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      uart_rx = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int glitch_c);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int c = 0; c < 10 * BIT; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      uart_rx = (c == glitch_c) ? 1'b0 : bits[c / BIT];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    uart_rx = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_single_byte;
    int base, fe0, ov0, lat;
    rx_ready = 1'b1;
    base = recv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, -1);
    idle(BIT);
    lat = rise_cyc - start_cyc;
    n_checks++; if (recv_cnt - base !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", recv_cnt - base); end
    n_checks++; if (recv_mem[base] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", recv_mem[base]); end
    n_checks++; if (lat < STOP_SAMPLE || lat > STOP_SAMPLE + 2) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, STOP_SAMPLE, STOP_SAMPLE + 2); end
    n_checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL single_errors: got %0d expected 0", fe_cnt - fe0 + ov_cnt - ov0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_clear: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [27];
    int base, fe0, ov0;
    exp_q[0] = 8'h5A; exp_q[1] = 8'hA1; exp_q[2] = 8'h12; exp_q[3] = 8'h34; exp_q[4] = 8'hBC;
    for (int i = 0; i < 20; i++) exp_q[5 + i] = 8'(i);
    exp_q[25] = 8'hC3; exp_q[26] = 8'h3C;
    rx_ready = 1'b1;
    base = recv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(exp_q[i], 1'b1, -1);
      idle(100);
    end
    for (int i = 5; i < 25; i++) begin
      send_frame(exp_q[i], 1'b1, -1);
      idle(50);
    end
    send_frame(exp_q[25], 1'b1, -1);
    send_frame(exp_q[26], 1'b1, -1);
    idle(BIT);
    n_checks++; if (recv_cnt - base !== 27) begin n_fail++; $display("FAIL b2b_count: got %0d expected 27", recv_cnt - base); end
    for (int i = 0; i < 27; i++) begin
      n_checks++;
      if (recv_mem[base + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, recv_mem[base + i], exp_q[i]);
      end
    end
    n_checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL b2b_errors: got %0d expected 0", fe_cnt - fe0 + ov_cnt - ov0); end
  endtask

  task automatic test_start_glitch;
    int base, fe0;
    base = recv_cnt; fe0 = fe_cnt;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (c == DETECT + HALF - 1) begin
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b expected 1", rx_busy); end
      end
      if (c == DETECT + HALF) begin
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b expected 0", rx_busy); end
      end
      uart_rx = (c < HALF - 12) ? 1'b0 : 1'b1;
    end
    idle(2 * BIT);
    n_checks++; if (recv_cnt - base !== 0) begin n_fail++; $display("FAIL glitch_no_byte: got %0d expected 0", recv_cnt - base); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_no_fe: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_error;
    int base, fe0, ov0;
    rx_ready = 1'b1;
    base = recv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, -1);
    repeat (3000) begin
      @(posedge clk); #1;
      uart_rx = 1'b0;
    end
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL fe_hold_busy: got %b expected 1", rx_busy); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulse_count: got %0d expected 1", fe_cnt - fe0); end
    idle(10);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL fe_release_busy: got %b expected 0", rx_busy); end
    idle(2 * BIT);
    n_checks++; if (recv_cnt - base !== 0) begin n_fail++; $display("FAIL fe_no_byte: got %0d expected 0", recv_cnt - base); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_no_retrigger: got %0d expected 1", fe_cnt - fe0); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL fe_no_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_overrun;
    int base, fe0, ov0;
    rx_ready = 1'b0;
    base = recv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, -1);
    idle(20);
    send_frame(8'h22, 1'b1, -1);
    idle(20);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_kept: got %h expected 11", rx_data); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL ovr_pulse_count: got %0d expected 1", ov_cnt - ov0); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL ovr_no_fe: got %0d expected 0", fe_cnt - fe0); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    idle(2);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_cleared: got %b expected 0", rx_valid); end
    n_checks++; if (recv_cnt - base !== 1) begin n_fail++; $display("FAIL ovr_take_count: got %0d expected 1", recv_cnt - base); end
    n_checks++; if (recv_mem[base] !== 8'h11) begin n_fail++; $display("FAIL ovr_take_data: got %h expected 11", recv_mem[base]); end
  endtask

  task automatic test_bit_glitch;
    int base;
    logic [7:0] exp_b;
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_b = 8'hFF;
`else
    exp_b = 8'hF7;
`endif
    rx_ready = 1'b1;
    base = recv_cnt;
    // Low for one clock so that it reaches sync exactly in bit 3's decision cycle.
    send_frame(8'hFF, 1'b1, HALF + 4 * BIT);
    idle(BIT);
    n_checks++; if (recv_cnt - base !== 1) begin n_fail++; $display("FAIL bitglitch_count: got %0d expected 1", recv_cnt - base); end
    n_checks++; if (recv_mem[base] !== exp_b) begin n_fail++; $display("FAIL bitglitch_data: got %h expected %h", recv_mem[base], exp_b); end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    rx_ready = 1'b1;
    base = recv_cnt;
    for (int c = 0; c < 5 * BIT; c++) begin
      @(posedge clk); #1;
      uart_rx = 1'b0;
    end
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", rx_busy); end
    rst = 1'b1;
    uart_rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b expected 0", rx_busy); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_after: got %b expected 0", rx_valid); end
    idle(12 * BIT);
    n_checks++; if (recv_cnt - base !== 0) begin n_fail++; $display("FAIL midrst_no_byte: got %0d expected 0", recv_cnt - base); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %b expected 0", rx_busy); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_start_glitch();
    test_frame_error();
    test_overrun();
    test_bit_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
